ir_issue_unit: RTL and testbench
================================

// Module: ir_issue_unit
// PURPOSE
//  Instruction feeder for the core: buffers 16-bit IR words written by a host or loader
//  in a FIFO and presents them one at a time to the core's IR input.
//  Uses a valid/ready handshake.
//  Supports free-run issue and single-step issue. In single-step mode, one word is issued
//  per rising edge of a slow step input (e.g. the DCLK-rate step/button line).
// PARAMETERS
//  IR_W    16  instruction word width
//  DEPTH    8  FIFO entries; must be a power of 2
//  ADDR_W   3  log2(DEPTH)
// PORTS
//  CLK         in   1         system clock; all logic on rising edge
//  RST         in   1         reset: synchronous, active-high
//  flush       in   1         clear FIFO and output register
//  wr_en       in   1         write request
//  wr_data     in   IR_W      instruction word to enqueue
//  full        out  1         FIFO holds DEPTH words
//  empty       out  1         FIFO holds 0 words (excludes output register)
//  count       out  ADDR_W+1  FIFO occupancy, 0..DEPTH (excludes output register)
//  step_mode   in   1         1 = single-step issue, 0 = free-run
//  step_in     in   1         asynchronous slow step line
//  ir_out      out  IR_W      instruction presented to the core
//  ir_valid    out  1         ir_out is valid
//  ir_ready    in   1         core accepts ir_out this cycle
//  issued_cnt  out  16        number of completed handshakes; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (RST=1 at a CLK edge):
//   - ptrs, count, ir_out, ir_valid, issued_cnt and step sync/edge regs all cleared to 0
//   - empty=1, full=0, FSM=IDLE; this applies even mid-handshake or mid-step
//  FIFO:
//   - Write accepted iff wr_en && !full && !flush.
//   - Write while full is dropped, even if a pop occurs in the same cycle. Contents unchanged.
//   - Pop = head moved into the ir_out register. Simultaneous write and pop: count unchanged.
//   - Pointers wrap modulo DEPTH.
//  step_in:
//   - Passes through a 2-FF synchronizer, then rising-edge detect; this produces a 1-cycle step pulse.
//   - Step pulses arriving in IDLE, in PRESENT, or with an empty FIFO are discarded, not queued.
//  FSM:
//   IDLE    ir_valid=0.
//           - step_mode=0 and !empty: pop into ir_out, go to PRESENT.
//           - step_mode=1: go to ARM.
//   ARM     ir_valid=0.
//           - step pulse and !empty: pop into ir_out, go to PRESENT.
//           - step_mode=0: go to IDLE.
//   PRESENT ir_valid=1. ir_out is held stable until ir_valid && ir_ready.
//           On handshake: issued_cnt+1, then:
//            - step_mode=0 and !empty: pop next word into ir_out, stay in PRESENT (1 word/cycle).
//            - step_mode=0 and empty: go to IDLE.
//            - step_mode=1: go to ARM.
//           A step_mode change during PRESENT takes effect only at the handshake.
//  Latency: in free-run, a word written (wr_en high) in cycle t into an empty unit gives ir_valid=1 in cycle t+2.
//  flush:
//   - Takes effect at the next edge: FIFO emptied, ir_valid=0, FSM goes to IDLE (or ARM if step_mode=1).
//   - flush beats wr_en and any handshake in the same cycle; that handshake is not counted.
//   - issued_cnt is not cleared by flush.
//  Capacity: up to DEPTH+1 words held in total (DEPTH in FIFO plus 1 in ir_out).
// TESTING
//  1 Reset: RST=1 for 3 cycles -> ir_valid=0, empty=1, full=0, count=0, issued_cnt=0.
//  2 Free-run: write 16'hC1FF with ir_ready=1 -> ir_out=C1FF, ir_valid=1 two cycles after write, then issued_cnt=1 and ir_valid=0.
//  3 Backpressure: write 1111,2222,3333 with ir_ready=0 for 6 cycles
//    -> ir_out holds 1111 and count=2; then ir_ready=1 -> 1111,2222,3333 on consecutive cycles, issued_cnt=3.
//  4 Overflow: DEPTH=8, ir_ready=0, write 10 words 0x0001..0x000A
//    -> ir_out=0001, count=8, full=1, word 000A dropped; draining yields 0001..0009 in order.
//  5 Single-step: step_mode=1, 3 words queued, ir_ready=1, step_in toggled every 20 CLKs
//    -> exactly one handshake per step_in rising edge, ir_valid=0 between; a 4th edge with empty FIFO issues nothing.
//  6 Flush mid-stream: 5 words queued, ir_valid=1; flush=1 together with wr_en=1 and ir_ready=1
//    -> next cycle empty=1, ir_valid=0, count=0, issued_cnt unchanged.

Source files
------------

// File: rtl/ir_issue_unit.sv
// ir_issue_unit: FIFO-buffered instruction feeder for the core IR input.
// Words written by a host/loader are queued and presented one at a time over a
// valid/ready handshake, either free-running or one word per step_in rising edge.
module ir_issue_unit #(
    parameter int IR_W   = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [IR_W-1:0]   wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    input  logic              step_mode,
    input  logic              step_in,
    output logic [IR_W-1:0]   ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [15:0]       issued_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [IR_W-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [IR_W-1:0]   ir_q;
    logic [15:0]       issued_q;
    logic              step_s1_q;
    logic              step_s2_q;
    logic              step_s3_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic              step_pulse;
    logic              wr_accept;
    logic              pop;
    logic              handshake;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    // s2 is the synchronised level, s3 its previous value: rising edge -> 1-cycle pulse
    assign step_pulse = step_s2_q & ~step_s3_q;
    // A write while full is dropped even if a pop frees a slot this cycle
    assign wr_accept  = wr_en & ~fifo_full & ~flush;

    assign full       = fifo_full;
    assign empty      = fifo_empty;
    assign count      = count_q;
    assign ir_out     = ir_q;
    assign ir_valid   = (state_q == ST_PRESENT);
    assign issued_cnt = issued_q;

    // Issue FSM next-state, pop and handshake decode; flush overrides everything
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        handshake = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!step_mode && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_PRESENT;
                end else if (step_mode) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (step_pulse && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_PRESENT;
                end else if (!step_mode) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (ir_ready) begin
                    handshake = 1'b1;
                    if (!step_mode && !fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_PRESENT;
                    end else if (!step_mode) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            pop       = 1'b0;
            handshake = 1'b0;
            state_d   = step_mode ? ST_ARM : ST_IDLE;
        end
    end

    // FIFO occupancy next value: simultaneous write and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (wr_accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage; contents need no reset since pointers/count define validity
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word register: loaded on pop, held through backpressure, cleared by flush
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            ir_q <= '0;
        end else if (pop) begin
            ir_q <= mem_q[rd_ptr_q];
        end
    end

    // Completed-handshake counter; survives flush, wraps naturally
    always_ff @(posedge CLK) begin
        if (RST) begin
            issued_q <= '0;
        end else if (handshake) begin
            issued_q <= issued_q + 16'd1;
        end
    end

    // Two-flop synchroniser plus edge-detect history for the slow step line
    always_ff @(posedge CLK) begin
        if (RST) begin
            step_s1_q <= 1'b0;
            step_s2_q <= 1'b0;
            step_s3_q <= 1'b0;
        end else begin
            step_s1_q <= step_in;
            step_s2_q <= step_s1_q;
            step_s3_q <= step_s2_q;
        end
    end

endmodule

// File: tb/tb_ir_issue_unit.sv
// tb_ir_issue_unit: directed scenarios plus a randomized run, checked every cycle
// against a queue-based reference model of the issue unit.
module tb_ir_issue_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        step_mode = 1'b0;
    logic        step_in = 1'b0;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [15:0] issued_cnt;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // reference model state
    logic [15:0] mq[$];
    bit          m_hold;      // a word is being presented
    bit          m_wait_step; // step mode armed, waiting for a step edge
    logic [15:0] m_out;
    logic [15:0] m_issued;
    bit          m_sync[3];   // step_in samples: [0] newest

    ir_issue_unit #(.IR_W(16), .DEPTH(8), .ADDR_W(3)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .step_mode(step_mode),
        .step_in(step_in), .ir_out(ir_out), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .issued_cnt(issued_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // one clock edge: advance the model with the inputs seen at the edge, then compare
    task automatic tick();
        bit          pulse;
        bit          was_full;
        bit          was_empty;
        bit          do_pop;
        logic [15:0] popped;
        @(posedge CLK);
        if (RST) begin
            mq.delete();
            m_hold = 0; m_wait_step = 0; m_out = '0; m_issued = '0;
            m_sync[0] = 0; m_sync[1] = 0; m_sync[2] = 0;
        end else begin
            pulse     = m_sync[1] && !m_sync[2];
            was_full  = (mq.size() == 8);
            was_empty = (mq.size() == 0);
            do_pop    = 0;
            if (flush) begin
                mq.delete();
                m_hold = 0; m_out = '0; m_wait_step = step_mode;
            end else begin
                if (m_hold) begin
                    if (ir_ready) begin
                        m_issued = m_issued + 16'd1;
                        if (!step_mode && !was_empty) do_pop = 1;
                        else begin m_hold = 0; m_wait_step = step_mode; end
                    end
                end else if (m_wait_step) begin
                    if (pulse && !was_empty) do_pop = 1;
                    else if (!step_mode) m_wait_step = 0;
                end else begin
                    if (!step_mode && !was_empty) do_pop = 1;
                    else if (step_mode) m_wait_step = 1;
                end
                if (do_pop) begin
                    popped = mq.pop_front();
                    m_out = popped; m_hold = 1; m_wait_step = 0;
                end
                if (wr_en && !was_full) mq.push_back(wr_data);
            end
            m_sync[2] = m_sync[1]; m_sync[1] = m_sync[0]; m_sync[0] = step_in;
        end
        #1;
        chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_hold});
        if (m_hold) chk("ir_out", {16'd0, ir_out}, {16'd0, m_out});
        chk("count", {28'd0, count}, mq.size());
        chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("full", {31'd0, full}, {31'd0, mq.size() == 8});
        chk("issued_cnt", {16'd0, issued_cnt}, {16'd0, m_issued});
    endtask

    initial begin
        logic [15:0] base;
        int unsigned vcycles;
        logic [15:0] expw;

        // 1: reset
        RST = 1'b1;
        repeat (3) tick();
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_issued", {16'd0, issued_cnt}, 32'd0);
        chk("rst_ir_out", {16'd0, ir_out}, 32'd0);
        RST = 1'b0;
        tick();

        // 2: free-run latency
        ir_ready = 1'b1; wr_en = 1'b1; wr_data = 16'hC1FF;
        tick();
        wr_en = 1'b0;
        chk("lat_t1_valid", {31'd0, ir_valid}, 32'd0);
        tick();
        chk("lat_t2_valid", {31'd0, ir_valid}, 32'd1);
        chk("lat_t2_out", {16'd0, ir_out}, 32'h0000C1FF);
        tick();
        chk("lat_issued", {16'd0, issued_cnt}, 32'd1);
        chk("lat_done_valid", {31'd0, ir_valid}, 32'd0);

        // 3: backpressure
        ir_ready = 1'b0;
        base = issued_cnt;
        wr_en = 1'b1;
        wr_data = 16'h1111; tick();
        wr_data = 16'h2222; tick();
        wr_data = 16'h3333; tick();
        wr_en = 1'b0;
        repeat (3) tick();
        chk("bp_hold", {16'd0, ir_out}, 32'h00001111);
        chk("bp_count", {28'd0, count}, 32'd2);
        ir_ready = 1'b1;
        tick(); chk("bp_w2", {16'd0, ir_out}, 32'h00002222);
        tick(); chk("bp_w3", {16'd0, ir_out}, 32'h00003333);
        tick();
        chk("bp_issued", {16'd0, issued_cnt - base}, 32'd3);

        // 4: overflow
        ir_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            wr_en = 1'b1; wr_data = 16'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("ovf_out", {16'd0, ir_out}, 32'd1);
        chk("ovf_count", {28'd0, count}, 32'd8);
        chk("ovf_full", {31'd0, full}, 32'd1);
        ir_ready = 1'b1;
        expw = 16'd1;
        for (int i = 0; i < 12; i++) begin
            if (ir_valid) begin
                chk("ovf_drain", {16'd0, ir_out}, {16'd0, expw});
                expw = expw + 16'd1;
            end
            tick();
        end
        chk("ovf_drained", {16'd0, expw}, 32'd10);

        // 5: single-step
        step_mode = 1'b1; ir_ready = 1'b1;
        base = issued_cnt;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 16'hA000 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("step_idle", {31'd0, ir_valid}, 32'd0);
        vcycles = 0;
        for (int e = 0; e < 8; e++) begin
            step_in = ~step_in;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (ir_valid) vcycles++;
            end
        end
        chk("step_issued", {16'd0, issued_cnt - base}, 32'd3);
        chk("step_vcycles", vcycles, 32'd3);

        // 6: flush mid-stream
        step_mode = 1'b0; ir_ready = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 16'hB000 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("fl_pre_valid", {31'd0, ir_valid}, 32'd1);
        base = issued_cnt;
        flush = 1'b1; wr_en = 1'b1; wr_data = 16'hDEAD; ir_ready = 1'b1;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        chk("fl_empty", {31'd0, empty}, 32'd1);
        chk("fl_valid", {31'd0, ir_valid}, 32'd0);
        chk("fl_count", {28'd0, count}, 32'd0);
        chk("fl_issued", {16'd0, issued_cnt}, {16'd0, base});
        chk("fl_out", {16'd0, ir_out}, 32'd0);
        tick();

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            wr_en    = ($urandom_range(0, 99) < 45);
            wr_data  = 16'($urandom);
            ir_ready = ($urandom_range(0, 99) < 55);
            flush    = ($urandom_range(0, 59) == 0);
            RST      = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 79) == 0) step_mode = ~step_mode;
            if ($urandom_range(0, 14) == 0) step_in = ~step_in;
            tick();
        end
        RST = 1'b0; flush = 1'b0; wr_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
